// File: rtl/blake2_msg_feeder.sv
// blake2_msg_feeder
//   Upstream stage of the blake2 core. Takes a message byte stream
//   (valid/ready) plus a per-message command (kk/nn, empty flag) and drives
//   the core's byte-load port one byte per strobe, zero-padding the final
//   block. An empty message becomes a single all-zero block. The producer
//   is held off while the core compresses a block (GAP) or streams its
//   result (WAIT_RES).
//
//   Optional feature macro: BLAKE2_KEY_BLOCK_EN
//     defined   - adds key_i; when kk>0 a key block (key bytes 0..kk-1, then
//                 zeros) is sent as the first block before the message.
//     undefined - kk is only latched and passed through on kk_o.
//
//   Ports
//     clk, nreset                 clock, async active-low reset
//     cmd_v_i/kk/nn/empty         message command, accepted only when idle
//     key_i                       key bytes (only with BLAKE2_KEY_BLOCK_EN)
//     s_valid_i/s_ready_o         message byte handshake
//     s_data_i, s_last_i          message byte, final-byte marker
//     h_v_i                       core result-valid
//     data_v_o/idx/data           byte strobe, index in block, byte
//     block_first_o/block_last_o  block flags (last may rise mid-block)
//     ll_o                        byte count (+BLK_BYTES if key block sent)
//     kk_o, nn_o                  latched kk/nn
//     busy_o                      message in progress
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | waiting for a command, producer held off
//   KEY      | emitting the key block (feature build only)
//   DATA     | accepting message bytes, one strobe per accepted byte
//   PAD      | emitting zero bytes up to the end of the final block
//   GAP      | core compressing a non-final block, producer held off
//   WAIT_RES | waiting for the core's result pulse to rise and fall

module blake2_msg_feeder #(
  parameter int BLK_BYTES = 64,
  parameter int IDX_W     = 7,
  parameter int LL_W      = 128,
  parameter int CNT_W     = 6,
  parameter int F_GAP     = 97
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   cmd_v_i,
  input  logic [CNT_W-1:0]       cmd_kk_i,
  input  logic [CNT_W-1:0]       cmd_nn_i,
  input  logic                   cmd_empty_i,
`ifdef BLAKE2_KEY_BLOCK_EN
  input  logic [8*BLK_BYTES-1:0] key_i,
`endif
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [7:0]             s_data_i,
  input  logic                   s_last_i,
  input  logic                   h_v_i,
  output logic                   data_v_o,
  output logic [IDX_W-1:0]       data_idx_o,
  output logic [7:0]             data_o,
  output logic                   block_first_o,
  output logic                   block_last_o,
  output logic [LL_W-1:0]        ll_o,
  output logic [CNT_W-1:0]       kk_o,
  output logic [CNT_W-1:0]       nn_o,
  output logic                   busy_o
);

  localparam int GAP_W = $clog2(F_GAP + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_DATA, S_PAD, S_GAP, S_WAIT_RES
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LL_W-1:0]    cnt_q, cnt_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   kk_q, kk_d;
  logic [CNT_W-1:0]   nn_q, nn_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               hv_q;
  logic               rose_q, rose_d;
  logic               dv_q, dv_d;
  logic [IDX_W-1:0]   didx_q, didx_d;
  logic [7:0]         dat_q, dat_d;
`ifdef BLAKE2_KEY_BLOCK_EN
  logic [8*BLK_BYTES-1:0] key_q, key_d;
  logic [8*BLK_BYTES-1:0] key_sh;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      kk_q    <= '0;
      nn_q    <= '0;
      gap_q   <= '0;
      hv_q    <= 1'b0;
      rose_q  <= 1'b0;
      dv_q    <= 1'b0;
      didx_q  <= '0;
      dat_q   <= '0;
`ifdef BLAKE2_KEY_BLOCK_EN
      key_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      last_q  <= last_d;
      kk_q    <= kk_d;
      nn_q    <= nn_d;
      gap_q   <= gap_d;
      hv_q    <= h_v_i;
      rose_q  <= rose_d;
      dv_q    <= dv_d;
      didx_q  <= didx_d;
      dat_q   <= dat_d;
`ifdef BLAKE2_KEY_BLOCK_EN
      key_q   <= key_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    last_d    = last_q;
    kk_d      = kk_q;
    nn_d      = nn_q;
    gap_d     = gap_q;
    rose_d    = rose_q;
    dv_d      = 1'b0;
    didx_d    = didx_q;
    dat_d     = dat_q;
    s_ready_o = 1'b0;
`ifdef BLAKE2_KEY_BLOCK_EN
    key_d     = key_q;
    key_sh    = key_q >> (8 * int'(idx_q));
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_v_i) begin
          kk_d    = cmd_kk_i;
          nn_d    = cmd_nn_i;
          first_d = 1'b1;
          last_d  = cmd_empty_i;
          cnt_d   = '0;
          idx_d   = '0;
          rose_d  = 1'b0;
          state_d = cmd_empty_i ? S_PAD : S_DATA;
`ifdef BLAKE2_KEY_BLOCK_EN
          key_d = key_i;
          if (cmd_kk_i != '0) begin
            // The key block counts as a full block of message bytes.
            cnt_d   = LL_W'(BLK_BYTES);
            state_d = S_KEY;
          end
`endif
        end
      end

`ifdef BLAKE2_KEY_BLOCK_EN
      S_KEY: begin
        dv_d   = 1'b1;
        didx_d = idx_q;
        dat_d  = (int'(idx_q) < int'(kk_q)) ? key_sh[7:0] : 8'h00;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (last_q) begin
            state_d = S_WAIT_RES;
          end else begin
            gap_d   = GAP_W'(F_GAP);
            state_d = S_GAP;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
`endif

      S_DATA: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          dv_d   = 1'b1;
          didx_d = idx_q;
          dat_d  = s_data_i;
          if (cnt_q != {LL_W{1'b1}}) cnt_d = cnt_q + LL_W'(1);
          if (s_last_i) begin
            last_d = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = S_WAIT_RES;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_PAD;
            end
          end else if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            gap_d   = GAP_W'(F_GAP);
            state_d = S_GAP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_PAD: begin
        dv_d   = 1'b1;
        didx_d = idx_q;
        dat_d  = 8'h00;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_WAIT_RES;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      // Timer is loaded on entry; the first GAP cycle carries the strobe of
      // byte BLK_BYTES-1, so F_GAP silent cycles follow before DATA.
      S_GAP: begin
        if (gap_q == '0) begin
          first_d = 1'b0;
          state_d = S_DATA;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      S_WAIT_RES: begin
        if (h_v_i && !hv_q) rose_d = 1'b1;
        if (rose_q && !h_v_i) begin
          rose_d  = 1'b0;
          first_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign data_v_o      = dv_q;
  assign data_idx_o    = didx_q;
  assign data_o        = dat_q;
  assign block_first_o = first_q;
  assign block_last_o  = last_q;
  assign ll_o          = cnt_q;
  assign kk_o          = kk_q;
  assign nn_o          = nn_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_blake2_msg_feeder.sv
// Directed bench for blake2_msg_feeder (default build, no key block).
// A negedge monitor records every byte strobe and every held-off stretch;
// the main thread drives messages and checks the recorded strobes against
// the expected block layout computed from the message length.

module tb_blake2_msg_feeder;

  localparam int BLK_BYTES = 64;
  localparam int IDX_W     = 7;
  localparam int LL_W      = 128;
  localparam int CNT_W     = 6;
  localparam int F_GAP     = 97;

  logic             clk;
  logic             nreset;
  logic             cmd_v_i;
  logic [CNT_W-1:0] cmd_kk_i;
  logic [CNT_W-1:0] cmd_nn_i;
  logic             cmd_empty_i;
  logic             s_valid_i;
  logic             s_ready_o;
  logic [7:0]       s_data_i;
  logic             s_last_i;
  logic             h_v_i;
  logic             data_v_o;
  logic [IDX_W-1:0] data_idx_o;
  logic [7:0]       data_o;
  logic             block_first_o;
  logic             block_last_o;
  logic [LL_W-1:0]  ll_o;
  logic [CNT_W-1:0] kk_o;
  logic [CNT_W-1:0] nn_o;
  logic             busy_o;

  blake2_msg_feeder #(
    .BLK_BYTES(BLK_BYTES), .IDX_W(IDX_W), .LL_W(LL_W),
    .CNT_W(CNT_W), .F_GAP(F_GAP)
  ) dut (
    .clk(clk), .nreset(nreset),
    .cmd_v_i(cmd_v_i), .cmd_kk_i(cmd_kk_i), .cmd_nn_i(cmd_nn_i),
    .cmd_empty_i(cmd_empty_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .s_last_i(s_last_i), .h_v_i(h_v_i),
    .data_v_o(data_v_o), .data_idx_o(data_idx_o), .data_o(data_o),
    .block_first_o(block_first_o), .block_last_o(block_last_o),
    .ll_o(ll_o), .kk_o(kk_o), .nn_o(nn_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [LL_W-1:0] got,
                     input logic [LL_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // strobe / hold-off monitor
  logic [7:0]       q_data  [$];
  logic [IDX_W-1:0] q_idx   [$];
  logic             q_first [$];
  logic             q_last  [$];
  logic [LL_W-1:0]  q_ll    [$];
  int               gaps    [$];
  int               quiet = 0;
  bit               rdy_seen = 0;

  always @(negedge clk) begin
    if (data_v_o) begin
      q_data.push_back(data_o);
      q_idx.push_back(data_idx_o);
      q_first.push_back(block_first_o);
      q_last.push_back(block_last_o);
      q_ll.push_back(ll_o);
    end
    if (s_ready_o) rdy_seen = 1;
    if (!busy_o) quiet = 0;
    else if (data_v_o || s_ready_o) begin
      if (quiet > 0 && s_ready_o && !data_v_o) gaps.push_back(quiet);
      quiet = 0;
    end else quiet++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [7:0] msg [0:255];

  task automatic clear_mon();
    q_data.delete(); q_idx.delete(); q_first.delete();
    q_last.delete(); q_ll.delete(); gaps.delete();
    rdy_seen = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_strobes(input int len, input string name);
    int nblk;
    int n;
    logic [7:0] exp_d;
    nblk = (len == 0) ? 1 : (len + BLK_BYTES - 1) / BLK_BYTES;
    n = nblk * BLK_BYTES;
    chk({name, ".count"}, LL_W'(q_data.size()), LL_W'(n));
    for (int j = 0; j < n && j < q_data.size(); j++) begin
      int b;
      b = j / BLK_BYTES;
      exp_d = (j < len) ? msg[j] : 8'h00;
      chk($sformatf("%s.idx[%0d]", name, j), LL_W'(q_idx[j]), LL_W'(j % BLK_BYTES));
      chk($sformatf("%s.data[%0d]", name, j), LL_W'(q_data[j]), LL_W'(exp_d));
      chk($sformatf("%s.first[%0d]", name, j), LL_W'(q_first[j]), LL_W'(b == 0));
      if (b != nblk - 1)
        chk($sformatf("%s.last[%0d]", name, j), LL_W'(q_last[j]), '0);
      else if (j % BLK_BYTES == BLK_BYTES - 1) begin
        chk($sformatf("%s.last[%0d]", name, j), LL_W'(q_last[j]), LL_W'(1));
        chk($sformatf("%s.ll[%0d]", name, j), q_ll[j], LL_W'(len));
      end
    end
  endtask

  // Sends one message; abort_at>=0 pulses nreset right after that byte's
  // strobe appears and returns without finishing the message.
  task automatic run_msg(input int len, input logic [CNT_W-1:0] kk,
                         input logic [CNT_W-1:0] nn, input bit throttle,
                         input int abort_at, input string name);
    int t;
    int nexp;
    clear_mon();
    cmd_kk_i = kk; cmd_nn_i = nn; cmd_empty_i = (len == 0); cmd_v_i = 1'b1;
    tick();
    cmd_v_i = 1'b0; cmd_empty_i = 1'b0;
    chk({name, ".busy_start"}, LL_W'(busy_o), LL_W'(1));
    for (int i = 0; i < len; i++) begin
      if (throttle && (i % 2 == 1)) begin
        s_valid_i = 1'b0;
        tick();
      end
      s_valid_i = 1'b1; s_data_i = msg[i]; s_last_i = (i == len - 1);
      t = 0;
      while (!s_ready_o && t < 300) begin tick(); t++; end
      if (t >= 300) begin
        chk({name, ".ready_timeout"}, LL_W'(t), '0);
        break;
      end
      tick();
      if (i == abort_at) begin
        s_valid_i = 1'b0; s_last_i = 1'b0;
        chk({name, ".pre_rst_v"}, LL_W'(data_v_o), LL_W'(1));
        chk({name, ".pre_rst_idx"}, LL_W'(data_idx_o), LL_W'(abort_at));
        nreset = 1'b0;
        #1;
        chk({name, ".rst_v"}, LL_W'(data_v_o), '0);
        chk({name, ".rst_idx"}, LL_W'(data_idx_o), '0);
        chk({name, ".rst_data"}, LL_W'(data_o), '0);
        chk({name, ".rst_first"}, LL_W'(block_first_o), '0);
        chk({name, ".rst_ll"}, ll_o, '0);
        chk({name, ".rst_busy"}, LL_W'(busy_o), '0);
        chk({name, ".rst_ready"}, LL_W'(s_ready_o), '0);
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        tick();
        return;
      end
    end
    s_valid_i = 1'b0; s_last_i = 1'b0;
    nexp = ((len == 0) ? 1 : (len + BLK_BYTES - 1) / BLK_BYTES) * BLK_BYTES;
    t = 0;
    while (q_data.size() < nexp && t < 500) begin tick(); t++; end
    // commands outside IDLE must be ignored
    cmd_v_i = 1'b1; cmd_empty_i = 1'b1;
    tick(); tick();
    cmd_v_i = 1'b0; cmd_empty_i = 1'b0;
    tick();
    check_strobes(len, name);
    chk({name, ".kk"}, LL_W'(kk_o), LL_W'(kk));
    chk({name, ".nn"}, LL_W'(nn_o), LL_W'(nn));
    chk({name, ".busy_wait"}, LL_W'(busy_o), LL_W'(1));
    h_v_i = 1'b1; tick(); tick();
    chk({name, ".busy_hv"}, LL_W'(busy_o), LL_W'(1));
    h_v_i = 1'b0; tick(); tick();
    chk({name, ".busy_end"}, LL_W'(busy_o), '0);
  endtask

  initial begin
    nreset = 1'b0; cmd_v_i = 1'b0; cmd_kk_i = '0; cmd_nn_i = '0;
    cmd_empty_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0; s_last_i = 1'b0;
    h_v_i = 1'b0;
    for (int i = 0; i < 256; i++) msg[i] = 8'((i * 37 + 11) & 8'hff);
    #1;
    chk("reset.data_v", LL_W'(data_v_o), '0);
    chk("reset.ready", LL_W'(s_ready_o), '0);
    chk("reset.busy", LL_W'(busy_o), '0);
    chk("reset.ll", ll_o, '0);
    chk("reset.kk", LL_W'(kk_o), '0);
    @(negedge clk); @(negedge clk);
    nreset = 1'b1;
    tick();

    // bytes offered while idle are ignored
    clear_mon();
    s_valid_i = 1'b1; s_data_i = 8'hAA; s_last_i = 1'b1;
    tick(); tick(); tick();
    s_valid_i = 1'b0; s_last_i = 1'b0;
    chk("idle.no_strobe", LL_W'(q_data.size()), '0);
    chk("idle.busy", LL_W'(busy_o), '0);
    chk("idle.ready", LL_W'(rdy_seen), '0);

    // "abc"
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg(3, 6'd0, 6'd0, 1'b0, -1, "abc");
    chk("abc.data0", LL_W'(q_data[0]), LL_W'(8'h61));
    chk("abc.data2", LL_W'(q_data[2]), LL_W'(8'h63));
    chk("abc.data3", LL_W'(q_data[3]), '0);

    // empty message
    run_msg(0, 6'd0, 6'd32, 1'b0, -1, "empty");
    chk("empty.ready_never", LL_W'(rdy_seen), '0);

    for (int i = 0; i < 256; i++) msg[i] = 8'((i * 37 + 11) & 8'hff);

    // exactly one block
    run_msg(64, 6'd0, 6'd64, 1'b0, -1, "b64");
    chk("b64.no_gap", LL_W'(gaps.size()), '0);

    // one block plus one byte
    run_msg(65, 6'd0, 6'd48, 1'b0, -1, "b65");
    chk("b65.gap_n", LL_W'(gaps.size()), LL_W'(1));
    if (gaps.size() > 0) chk("b65.gap_len", LL_W'(gaps[0]), LL_W'(F_GAP));

    // throttled producer
    run_msg(50, 6'd0, 6'd20, 1'b1, -1, "thr");

    // reset mid-block, then a clean restart
    run_msg(100, 6'd0, 6'd64, 1'b0, 20, "rst");
    chk("rst.busy_after", LL_W'(busy_o), '0);
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg(3, 6'd0, 6'd64, 1'b0, -1, "restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
